lc3_execute: RTL and testbench

- LC3 execute stage, sitting directly upstream of writeback.
- Decodes the instruction from decode, selects operands from the writeback register-file read values (VSR1/VSR2) or bypass sources, and performs ALU or effective-address computation.
- Registers results, destination and control for the writeback and memory-access stages.
- Drives sr1/sr2 combinationally so writeback can return VSR1/VSR2 in the same cycle.

---
 rtl/lc3_execute_pkg.sv | 68 ++++++
 rtl/lc3_execute_if.sv | 45 ++++
 rtl/lc3_execute_alu.sv | 51 +++++
 rtl/lc3_execute.sv | 96 +++++++++
 tb/tb_lc3_execute.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/lc3_execute_pkg.sv
// Shared definitions for the LC3 execute stage: opcodes, control encodings,
// E_Control field positions and sign-extension helpers.
package lc3_execute_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic [3:0] OpBr  = 4'b0000;
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpLd  = 4'b0010;
    localparam logic [3:0] OpAnd = 4'b0101;
    localparam logic [3:0] OpLdr = 4'b0110;
    localparam logic [3:0] OpNot = 4'b1001;
    localparam logic [3:0] OpLdi = 4'b1010;
    localparam logic [3:0] OpJmp = 4'b1100;
    localparam logic [3:0] OpLea = 4'b1110;

    typedef enum logic [1:0] {
        AluAdd  = 2'b00,
        AluAnd  = 2'b01,
        AluNot  = 2'b10,
        AluRsvd = 2'b11
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        PcOff11 = 2'b00,
        PcOff9  = 2'b01,
        PcOff6  = 2'b10,
        PcZero  = 2'b11
    } pc_sel1_e;

    typedef enum logic {
        Op2Imm = 1'b0,
        Op2Reg = 1'b1
    } op2_sel_e;

    localparam int unsigned ECtlAluHi = 5;
    localparam int unsigned ECtlAluLo = 4;
    localparam int unsigned ECtlPc1Hi = 3;
    localparam int unsigned ECtlPc1Lo = 2;
    localparam int unsigned ECtlPc2   = 1;
    localparam int unsigned ECtlOp2   = 0;

    function automatic logic [DATA_W-1:0] sext5(input logic [4:0] v);
        return {{(DATA_W-5){v[4]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext6(input logic [5:0] v);
        return {{(DATA_W-6){v[5]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext9(input logic [8:0] v);
        return {{(DATA_W-9){v[8]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext11(input logic [10:0] v);
        return {{(DATA_W-11){v[10]}}, v};
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OpAdd) || (op == OpAnd) || (op == OpNot);
    endfunction

    function automatic logic writes_dr(input logic [3:0] op);
        return is_alu_op(op) || (op == OpLd) || (op == OpLdr) || (op == OpLdi) ||
               (op == OpLea);
    endfunction

endpackage

// File: rtl/lc3_execute_if.sv
// Execute-stage bus: decode/writeback inputs and registered results.
interface lc3_execute_if;
    import lc3_execute_pkg::*;

    logic              enable_execute;
    logic [DATA_W-1:0] IR;
    logic [DATA_W-1:0] npc_in;
    logic [5:0]        E_Control;
    logic [1:0]        W_Control_in;
    logic              Mem_Control_in;
    logic [DATA_W-1:0] VSR1;
    logic [DATA_W-1:0] VSR2;
    logic [DATA_W-1:0] Mem_Bypass_Val;
    logic              bypass_alu_1;
    logic              bypass_alu_2;
    logic              bypass_mem_1;
    logic              bypass_mem_2;
    logic [2:0]        sr1;
    logic [2:0]        sr2;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] pcout;
    logic [DATA_W-1:0] M_Data;
    logic [2:0]        dr;
    logic [2:0]        NZP;
    logic [1:0]        W_Control_out;
    logic              Mem_Control_out;
    logic [DATA_W-1:0] IR_Exec;

    modport master (
        output enable_execute, IR, npc_in, E_Control, W_Control_in, Mem_Control_in,
               VSR1, VSR2, Mem_Bypass_Val, bypass_alu_1, bypass_alu_2, bypass_mem_1,
               bypass_mem_2,
        input  sr1, sr2, aluout, pcout, M_Data, dr, NZP, W_Control_out, Mem_Control_out,
               IR_Exec
    );

    modport slave (
        input  enable_execute, IR, npc_in, E_Control, W_Control_in, Mem_Control_in,
               VSR1, VSR2, Mem_Bypass_Val, bypass_alu_1, bypass_alu_2, bypass_mem_1,
               bypass_mem_2,
        output sr1, sr2, aluout, pcout, M_Data, dr, NZP, W_Control_out, Mem_Control_out,
               IR_Exec
    );

endinterface

// File: rtl/lc3_execute_alu.sv
// Combinational ALU and effective-address adder of the execute stage.
module lc3_execute_alu
    import lc3_execute_pkg::*;
(
    input  logic [10:0]       ir_off_i,
    input  logic [5:0]        e_control_i,
    input  logic [DATA_W-1:0] npc_i,
    input  logic [DATA_W-1:0] val1_i,
    input  logic [DATA_W-1:0] val2_i,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] pc_result_o
);

    alu_ctrl_e         alu_ctrl;
    pc_sel1_e          pc_sel1;
    op2_sel_e          op2_sel;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] addend1;
    logic [DATA_W-1:0] addend2;

    assign alu_ctrl = alu_ctrl_e'(e_control_i[ECtlAluHi:ECtlAluLo]);
    assign pc_sel1  = pc_sel1_e'(e_control_i[ECtlPc1Hi:ECtlPc1Lo]);
    assign op2_sel  = op2_sel_e'(e_control_i[ECtlOp2]);

    assign op2     = (op2_sel == Op2Reg) ? val2_i : sext5(ir_off_i[4:0]);
    assign addend2 = e_control_i[ECtlPc2] ? npc_i : val1_i;

    always_comb begin
        alu_result_o = '0;
        unique case (alu_ctrl)
            AluAdd:  alu_result_o = val1_i + op2;
            AluAnd:  alu_result_o = val1_i & op2;
            AluNot:  alu_result_o = ~val1_i;
            default: alu_result_o = '0;
        endcase
    end

    always_comb begin
        addend1 = '0;
        unique case (pc_sel1)
            PcOff11: addend1 = sext11(ir_off_i);
            PcOff9:  addend1 = sext9(ir_off_i[8:0]);
            PcOff6:  addend1 = sext6(ir_off_i[5:0]);
            default: addend1 = '0;
        endcase
    end

    // Carry out is dropped: address arithmetic wraps modulo 2^16.
    assign pc_result_o = addend1 + addend2;

endmodule

// File: rtl/lc3_execute.sv
// LC3 execute stage: operand forwarding, ALU/address compute and result registers.
// Optional forwarding is enabled by defining LC3_EXECUTE_BYPASS_EN.
module lc3_execute
    import lc3_execute_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    lc3_execute_if.slave ex
);

    logic [3:0]        opcode;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] pc_result;

    logic [DATA_W-1:0] aluout_d, aluout_q;
    logic [DATA_W-1:0] pcout_d, pcout_q;
    logic [DATA_W-1:0] m_data_d, m_data_q;
    logic [2:0]        dr_d, dr_q;
    logic [2:0]        nzp_d, nzp_q;
    logic [1:0]        w_control_q;
    logic              mem_control_q;
    logic [DATA_W-1:0] ir_exec_q;

    assign opcode = ex.IR[15:12];
    assign ex.sr1 = ex.IR[8:6];
    assign ex.sr2 = ((opcode == OpAdd) || (opcode == OpAnd)) ? ex.IR[2:0] : ex.IR[11:9];

`ifdef LC3_EXECUTE_BYPASS_EN
    // ALU forwarding takes priority over memory forwarding.
    assign val1 = ex.bypass_alu_1 ? aluout_q : ex.bypass_mem_1 ? ex.Mem_Bypass_Val : ex.VSR1;
    assign val2 = ex.bypass_alu_2 ? aluout_q : ex.bypass_mem_2 ? ex.Mem_Bypass_Val : ex.VSR2;
`else
    logic unused_bypass;
    assign unused_bypass = ^{ex.bypass_alu_1, ex.bypass_alu_2, ex.bypass_mem_1,
                             ex.bypass_mem_2, ex.Mem_Bypass_Val};
    assign val1 = ex.VSR1;
    assign val2 = ex.VSR2;
`endif

    lc3_execute_alu u_alu (
        .ir_off_i     (ex.IR[10:0]),
        .e_control_i  (ex.E_Control),
        .npc_i        (ex.npc_in),
        .val1_i       (val1),
        .val2_i       (val2),
        .alu_result_o (alu_result),
        .pc_result_o  (pc_result)
    );

    always_comb begin
        aluout_d = is_alu_op(opcode) ? alu_result : pc_result;
        pcout_d  = pc_result;
        m_data_d = val2;
        dr_d     = writes_dr(opcode) ? ex.IR[11:9] : 3'b000;
        nzp_d    = 3'b000;
        if (opcode == OpBr) begin
            nzp_d = ex.IR[11:9];
        end else if (opcode == OpJmp) begin
            nzp_d = 3'b111;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            aluout_q      <= '0;
            pcout_q       <= '0;
            m_data_q      <= '0;
            dr_q          <= '0;
            nzp_q         <= '0;
            w_control_q   <= '0;
            mem_control_q <= 1'b0;
            ir_exec_q     <= '0;
        end else if (ex.enable_execute) begin
            aluout_q      <= aluout_d;
            pcout_q       <= pcout_d;
            m_data_q      <= m_data_d;
            dr_q          <= dr_d;
            nzp_q         <= nzp_d;
            w_control_q   <= ex.W_Control_in;
            mem_control_q <= ex.Mem_Control_in;
            ir_exec_q     <= ex.IR;
        end
    end

    assign ex.aluout          = aluout_q;
    assign ex.pcout           = pcout_q;
    assign ex.M_Data          = m_data_q;
    assign ex.dr              = dr_q;
    assign ex.NZP             = nzp_q;
    assign ex.W_Control_out   = w_control_q;
    assign ex.Mem_Control_out = mem_control_q;
    assign ex.IR_Exec         = ir_exec_q;

endmodule

// File: tb/tb_lc3_execute.sv
// Self-checking bench for lc3_execute: directed cases then random stimulus vs a behavioural model.
module tb_lc3_execute;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    lc3_execute_if ex_if ();

    lc3_execute dut (
        .clock (clock),
        .reset (reset),
        .ex    (ex_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the registered outputs
    logic [15:0] m_alu = '0, m_pc = '0, m_mdata = '0, m_ir = '0;
    logic [2:0]  m_dr = '0, m_nzp = '0;
    logic [1:0]  m_wc = '0;
    logic        m_mc = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
        logic signed [15:0] t;
        t = v << (16 - bits);
        return t >>> (16 - bits);
    endfunction

    task automatic step(input logic rst, input logic en, input logic [15:0] ir,
                        input logic [15:0] npc, input logic [5:0] ectl, input logic [1:0] wc,
                        input logic mc, input logic [15:0] v1r, input logic [15:0] v2r,
                        input logic [15:0] mbv, input logic [3:0] byp);
        int op;
        logic [15:0] v1, v2, op2, alu, a1, pc;
        reset                  = rst;
        ex_if.enable_execute   = en;
        ex_if.IR               = ir;
        ex_if.npc_in           = npc;
        ex_if.E_Control        = ectl;
        ex_if.W_Control_in     = wc;
        ex_if.Mem_Control_in   = mc;
        ex_if.VSR1             = v1r;
        ex_if.VSR2             = v2r;
        ex_if.Mem_Bypass_Val   = mbv;
        {ex_if.bypass_alu_1, ex_if.bypass_alu_2, ex_if.bypass_mem_1, ex_if.bypass_mem_2} = byp;
        #1;
        op = int'(ir[15:12]);
        chk("sr1", {13'd0, ex_if.sr1}, {13'd0, ir[8:6]});
        chk("sr2", {13'd0, ex_if.sr2}, (op == 1 || op == 5) ? {13'd0, ir[2:0]} :
                                                             {13'd0, ir[11:9]});
`ifdef LC3_EXECUTE_BYPASS_EN
        v1 = byp[3] ? m_alu : (byp[1] ? mbv : v1r);
        v2 = byp[2] ? m_alu : (byp[0] ? mbv : v2r);
`else
        v1 = v1r;
        v2 = v2r;
`endif
        op2 = ectl[0] ? v2 : sx(ir, 5);
        case (ectl[5:4])
            2'd0:    alu = v1 + op2;
            2'd1:    alu = v1 & op2;
            2'd2:    alu = ~v1;
            default: alu = 16'h0000;
        endcase
        case (ectl[3:2])
            2'd0:    a1 = sx(ir, 11);
            2'd1:    a1 = sx(ir, 9);
            2'd2:    a1 = sx(ir, 6);
            default: a1 = 16'h0000;
        endcase
        pc = a1 + (ectl[1] ? npc : v1);
        @(posedge clock);
        #1;
        if (rst) begin
            {m_alu, m_pc, m_mdata, m_ir, m_dr, m_nzp, m_wc, m_mc} = '0;
        end else if (en) begin
            m_alu   = (op == 1 || op == 5 || op == 9) ? alu : pc;
            m_pc    = pc;
            m_mdata = v2;
            m_dr    = (op == 1 || op == 5 || op == 9 || op == 2 || op == 6 || op == 10 ||
                       op == 14) ? ir[11:9] : 3'b000;
            m_nzp   = (op == 0) ? ir[11:9] : ((op == 12) ? 3'b111 : 3'b000);
            m_wc    = wc;
            m_mc    = mc;
            m_ir    = ir;
        end
        chk("aluout", ex_if.aluout, m_alu);
        chk("pcout", ex_if.pcout, m_pc);
        chk("M_Data", ex_if.M_Data, m_mdata);
        chk("dr", {13'd0, ex_if.dr}, {13'd0, m_dr});
        chk("NZP", {13'd0, ex_if.NZP}, {13'd0, m_nzp});
        chk("W_Control_out", {14'd0, ex_if.W_Control_out}, {14'd0, m_wc});
        chk("Mem_Control_out", {15'd0, ex_if.Mem_Control_out}, {15'd0, m_mc});
        chk("IR_Exec", ex_if.IR_Exec, m_ir);
    endtask

    initial begin
        // Reset overrides enable
        step(1'b1, 1'b1, 16'h1042, 16'h1234, 6'b000001, 2'b11, 1'b1, 16'h0005, 16'hFFFE,
             16'h0000, 4'b0000);
        chk("rst_aluout", ex_if.aluout, 16'h0000);
        chk("rst_NZP", {13'd0, ex_if.NZP}, 16'h0000);
        chk("rst_IR_Exec", ex_if.IR_Exec, 16'h0000);

        step(1'b0, 1'b1, 16'h1042, 16'h3000, 6'b000001, 2'b01, 1'b0, 16'h0005, 16'hFFFE,
             16'h0000, 4'b0000);
        chk("add_reg_aluout", ex_if.aluout, 16'h0003);
        chk("add_reg_dr", {13'd0, ex_if.dr}, 16'h0000);

        step(1'b0, 1'b1, 16'h5261, 16'h3001, 6'b010000, 2'b00, 1'b0, 16'h00F3, 16'h0000,
             16'h0000, 4'b0000);
        chk("and_imm_aluout", ex_if.aluout, 16'h0001);
        chk("and_imm_dr", {13'd0, ex_if.dr}, 16'h0001);

        step(1'b0, 1'b1, 16'h0BFE, 16'h3001, 6'b000110, 2'b00, 1'b0, 16'h1111, 16'h2222,
             16'h0000, 4'b0000);
        chk("br_pcout", ex_if.pcout, 16'h2FFF);
        chk("br_NZP", {13'd0, ex_if.NZP}, 16'h0005);
        chk("br_dr", {13'd0, ex_if.dr}, 16'h0000);

        // Stall with changing inputs: outputs hold
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 16'($urandom), 16'($urandom), 6'($urandom), 2'($urandom),
                 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'b0000);
            chk("stall_pcout", ex_if.pcout, 16'h2FFF);
        end

        // LEA with offset -1 from FF01, sum wraps past 2^16
        step(1'b0, 1'b1, 16'hE1FF, 16'hFF01, 6'b000110, 2'b00, 1'b0, 16'h0000, 16'h0000,
             16'h0000, 4'b0000);
        chk("lea_pcout", ex_if.pcout, 16'hFF00);
        chk("lea_aluout", ex_if.aluout, 16'hFF00);

        // Forwarding: prime aluout = 0x0010, then ADD R0,R1,#1 with both selects on
        step(1'b0, 1'b1, 16'h1061, 16'h0000, 6'b000000, 2'b00, 1'b0, 16'h000F, 16'h0000,
             16'h0000, 4'b0000);
        chk("byp_prime", ex_if.aluout, 16'h0010);
        step(1'b0, 1'b1, 16'h1061, 16'h0000, 6'b000000, 2'b00, 1'b0, 16'h0000, 16'h0000,
             16'h0020, 4'b1010);
`ifdef LC3_EXECUTE_BYPASS_EN
        chk("byp_alu_wins", ex_if.aluout, 16'h0011);
`else
        chk("byp_ignored", ex_if.aluout, 16'h0001);
`endif
        step(1'b0, 1'b1, 16'h1061, 16'h0000, 6'b000000, 2'b00, 1'b0, 16'h0000, 16'h4444,
             16'h0020, 4'b0011);
`ifdef LC3_EXECUTE_BYPASS_EN
        chk("byp_mem", ex_if.aluout, 16'h0021);
        chk("byp_mem_mdata", ex_if.M_Data, 16'h0020);
`else
        chk("byp_mem_ignored", ex_if.aluout, 16'h0001);
        chk("byp_mem_mdata", ex_if.M_Data, 16'h4444);
`endif

        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 16'($urandom),
                 16'($urandom), 6'($urandom), 2'($urandom), 1'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
